// File: rtl/pipe_alu_core.sv
// Four-stage register-file/ALU pipeline: accept, operand read, execute, writeback.
// Full forwarding from S2/S3; the only stall source is writeback backpressure.
module pipe_alu_core #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned CNT_W    = 32,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic [DW-1:0]    instr_imm,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [AW-1:0]    wb_rd,
    output logic [DW-1:0]    wb_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [DW-1:0]    dbg_data,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned SHW = $clog2(DW);

    typedef enum logic [2:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSlt, OpLi
    } op_e;

    // S1: accepted instruction
    logic          s1_valid_q;
    op_e           s1_op_q;
    logic [AW-1:0] s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [DW-1:0] s1_imm_q;

    // S2: latched operands
    logic          s2_valid_q;
    op_e           s2_op_q;
    logic [AW-1:0] s2_rd_q;
    logic [DW-1:0] s2_a_q, s2_b_q, s2_imm_q;

    // S3: result awaiting writeback
    logic          s3_valid_q;
    logic [AW-1:0] s3_rd_q;
    logic [DW-1:0] s3_data_q;

    logic [DW-1:0]    regs_q [NREGS];
    logic [CNT_W-1:0] cnt_q;

    logic          adv;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] s2_a_d, s2_b_d;
    logic          wr_en;

    assign adv = !s3_valid_q || wb_ready;

    always_comb begin
        alu_res = '0;
        unique case (s2_op_q)
            OpAdd: alu_res = s2_a_q + s2_b_q;
            OpSub: alu_res = s2_a_q - s2_b_q;
            OpAnd: alu_res = s2_a_q & s2_b_q;
            OpOr:  alu_res = s2_a_q | s2_b_q;
            OpXor: alu_res = s2_a_q ^ s2_b_q;
            OpSll: alu_res = s2_a_q << s2_b_q[SHW-1:0];
            OpSlt: alu_res = DW'($signed(s2_a_q) < $signed(s2_b_q));
            OpLi:  alu_res = s2_imm_q;
        endcase
    end

    // Hardwired zero beats forwarding, so rd==0 never acts as a forwarding source.
    always_comb begin
        if ((ZERO_REG != 0) && (s1_rs1_q == '0)) begin
            s2_a_d = '0;
        end else if (s2_valid_q && (s2_rd_q == s1_rs1_q)) begin
            s2_a_d = alu_res;
        end else if (s3_valid_q && (s3_rd_q == s1_rs1_q)) begin
            s2_a_d = s3_data_q;
        end else begin
            s2_a_d = regs_q[s1_rs1_q];
        end

        if ((ZERO_REG != 0) && (s1_rs2_q == '0)) begin
            s2_b_d = '0;
        end else if (s2_valid_q && (s2_rd_q == s1_rs2_q)) begin
            s2_b_d = alu_res;
        end else if (s3_valid_q && (s3_rd_q == s1_rs2_q)) begin
            s2_b_d = s3_data_q;
        end else begin
            s2_b_d = regs_q[s1_rs2_q];
        end
    end

    assign wr_en = (ZERO_REG == 0) || (s3_rd_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OpAdd;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_imm_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q    <= OpAdd;
            s2_rd_q    <= '0;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            s2_imm_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_rd_q    <= '0;
            s3_data_q  <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (adv) begin
            s1_valid_q <= instr_valid;
            s1_op_q    <= op_e'(instr_op);
            s1_rd_q    <= instr_rd;
            s1_rs1_q   <= instr_rs1;
            s1_rs2_q   <= instr_rs2;
            s1_imm_q   <= instr_imm;
            s2_valid_q <= s1_valid_q;
            s2_op_q    <= s1_op_q;
            s2_rd_q    <= s1_rd_q;
            s2_a_q     <= s2_a_d;
            s2_b_q     <= s2_b_d;
            s2_imm_q   <= s1_imm_q;
            s3_valid_q <= s2_valid_q;
            s3_rd_q    <= s2_rd_q;
            s3_data_q  <= alu_res;
            if (s3_valid_q) begin
                if (wr_en) begin
                    regs_q[s3_rd_q] <= s3_data_q;
                end
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign instr_ready  = adv && !reset;
    assign wb_valid     = s3_valid_q && !reset;
    assign wb_rd        = s3_rd_q;
    assign wb_data      = s3_data_q;
    assign retire_count = cnt_q;
    assign dbg_data     = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

endmodule
